mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port, synchronous-read instruction/data RAM between the fetch unit (read-only) and the load/store unit (reads and byte-masked writes). It sequences each access against the RAM's one-cycle read latency. The RAM only supports whole-word writes, so partial (byte/halfword) stores are carried out as a read-modify-write. It sits between the core and the RAM and owns the RAM's `we`/`addr`/`din` pins.

## Interface
Parameters:
- `FAIR`, default 1: 1 selects round-robin between I and D on simultaneous requests; 0 selects fixed D priority.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request.
- `i_addr` in 32: fetch byte address.
- `i_gnt` out 1: fetch request accepted this cycle.
- `i_ack` out 1: fetch data valid this cycle.
- `i_rdata` out 32: fetch data; meaningful only while `i_ack`.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, lane-aligned.
- `d_wstrb` in 4: store byte enables; bit k selects bits [8k+7:8k].
- `d_gnt` out 1: data request accepted this cycle.
- `d_ack` out 1: load data valid / store complete.
- `d_rdata` out 32: load data; meaningful only while `d_ack`.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 32: RAM address; bits [1:0] are driven 0.
- `mem_din` out 32: RAM write data.
- `mem_dout` in 32: RAM registered read data.

## Operation
States: IDLE, RD_WAIT, WR_ACK, RMW_MERGE, RMW_ACK.

Grant and capture:
- Grants happen only in IDLE.
- The granted requester's `addr`, `we`, `wdata` and `wstrb` are captured into internal registers in the grant cycle. The requester may change its inputs from the next cycle.

Arbitration on simultaneous `i_req` and `d_req`:
- FAIR=0: D wins.
- FAIR=1: a `last_d` flag is set on every D grant and cleared on every I grant. I wins if `last_d`=1, otherwise D wins.
- `last_d` resets to 0, so D wins the first tie after reset.

Actions in the IDLE grant cycle. The RAM signals are driven combinationally from the request inputs in this cycle, and from the captured registers in all later states.
- I read, or D load: `mem_addr` = {addr[31:2], 2'b00}, `mem_we` = 0. Next state is RD_WAIT.
- D store with `wstrb` = 4'b1111: `mem_we` = 1, `mem_din` = `wdata`. Next state is WR_ACK.
- D store with `wstrb` = 4'b0000: no RAM write. Next state is WR_ACK (a no-op store that is still acknowledged).
- D store with any other `wstrb`: read the word. Next state is RMW_MERGE.

Actions in the later states:
- RD_WAIT: `i_ack` or `d_ack` = 1 for the owner; `*_rdata` = `mem_dout`. Next state is IDLE.
- WR_ACK: `d_ack` = 1. Next state is IDLE.
- RMW_MERGE:
  - `mem_we` = 1.
  - `mem_din` byte k = `wstrb[k]` ? `wdata` byte k : `mem_dout` byte k.
  - Same captured address as the read.
  - Next state is RMW_ACK.
- RMW_ACK: `d_ack` = 1. Next state is IDLE.

Other rules:
- The arbiter does no alignment checking. Address bits [1:0] are ignored and lanes are selected only by `wstrb`.
- A request is not sampled in the ack cycle. A requester holding `req` through its ack cycle is granted again at the earliest in the following IDLE cycle; this is treated as a new access.

## Timing
- Grant to ack:
  - Read: 1 cycle.
  - Full-word or zero-strobe store: 1 cycle.
  - Partial store: 2 cycles.
- Peak throughput: one access every 2 cycles (3 cycles for a partial store).
- `gnt` is a combinational one-cycle pulse in IDLE. `ack` is a one-cycle pulse decoded from state.
- Reset values: state = IDLE, `last_d` = 0.
  - With `rst` = 1: `i_gnt`, `d_gnt`, `i_ack`, `d_ack` and `mem_we` are all 0.
  - `mem_addr` and `mem_din` are 0 while in reset.
- `mem_we` is gated by `rst`: no RAM write occurs in any cycle where `rst` = 1. This includes a reset asserted during RMW_MERGE, in which case the word is left unmodified and no ack is issued.
- Reset during RD_WAIT or WR_ACK: the ack is suppressed. The requester must reissue the access after reset.
- No request is granted in a cycle where `rst` = 1.

## Test plan
1. Word read: RAM[0x10] = 0xDEADBEEF, `i_req` with `i_addr` = 0x40 at cycle N. Expect `i_gnt` at N; `i_ack` at N+1 with `i_rdata` = 0xDEADBEEF; `mem_we` = 0 throughout.
2. Byte store RMW: RAM[1] = 0x11223344, `d_req`/`d_we` with `d_addr` = 0x4, `d_wstrb` = 4'b0100, `d_wdata` = 0x00AB0000. Expect a write at N+1 with `mem_din` = 0x11AB3344, `d_ack` at N+2, and a subsequent read returning 0x11AB3344.
3. Tie with FAIR=1: `i_req` and `d_req` held high continuously after reset. Grant order D, I, D, I …, each grant in an IDLE cycle separated by ack cycles. With FAIR=0: only D grants for as long as `d_req` stays high.
4. Full-word and zero-strobe stores: `wstrb` = 4'b1111 with 0xCAFEF00D gives `mem_we` only at N and `d_ack` at N+1. `wstrb` = 4'b0000 gives `mem_we` never asserted, `d_ack` at N+1, and RAM unchanged.
5. Reset in RMW_MERGE: `rst` = 1 on the cycle after a partial-store grant. Expect `mem_we` = 0, no `d_ack`, state IDLE next cycle, and the RAM word unchanged.
6. Input change after grant: change `d_addr`/`d_wdata` in the cycle after `d_gnt` of a partial store. Expect the merge and write to use the captured values only.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port synchronous-read RAM between fetch and load/store,
// turning partial stores into a read-modify-write.
module mem_port_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_ACK, RMW_MERGE, RMW_ACK} state_t;
    state_t state, state_nx;
    logic last_d;
    logic [29:0] c_addr;
    logic [31:0] c_wdata, merged;
    logic [3:0] c_wstrb;
    logic pick_d, pick_i, full, zero;
    logic unused_lsb;
    assign unused_lsb = ^{i_addr[1:0], d_addr[1:0]};
    always_comb begin
        pick_d = state == IDLE && !rst && d_req && (!i_req || !FAIR || !last_d);
        pick_i = state == IDLE && !rst && i_req && !pick_d;
        full = d_we && d_wstrb == 4'hf;
        zero = d_we && d_wstrb == 4'h0;
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = c_wstrb[k] ? c_wdata[8*k +: 8] : mem_dout[8*k +: 8];
        state_nx = IDLE;
        case (state)
            IDLE:      state_nx = pick_i || (pick_d && !d_we) ? RD_WAIT :
                                  pick_d ? (full || zero ? WR_ACK : RMW_MERGE) : IDLE;
            RMW_MERGE: state_nx = RMW_ACK;
            default:   state_nx = IDLE;
        endcase
    end
    // last_d doubles as the owner of the access in flight: it always names the last grant.
    always_comb begin
        i_gnt = pick_i;
        d_gnt = pick_d;
        i_ack = !rst && state == RD_WAIT && !last_d;
        d_ack = !rst && ((state == RD_WAIT && last_d) || state == WR_ACK || state == RMW_ACK);
        i_rdata = mem_dout;
        d_rdata = mem_dout;
        mem_we = (pick_d && full) || (!rst && state == RMW_MERGE);
        mem_addr = rst ? 32'h0 :
                   state != IDLE ? {c_addr, 2'b00} :
                   pick_d ? {d_addr[31:2], 2'b00} :
                   pick_i ? {i_addr[31:2], 2'b00} : 32'h0;
        mem_din = rst ? 32'h0 :
                  state == RMW_MERGE ? merged :
                  pick_d && full ? d_wdata : 32'h0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_nx;
            if (pick_d || pick_i) last_d <= pick_d;
        end
    end
    always_ff @(posedge clk) begin
        if (pick_d || pick_i) begin
            c_addr <= pick_d ? d_addr[31:2] : i_addr[31:2];
            c_wdata <= d_wdata;
            c_wstrb <= d_wstrb;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized traffic against a word-level reference model with an ack scoreboard.
module tb_mem_port_arbiter;
    localparam bit FAIR = 1'b1;
    logic clk = 1'b0, rst;
    logic i_req, i_gnt, i_ack, d_req, d_we, d_gnt, d_ack, mem_we;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_din, mem_dout;
    logic [3:0] d_wstrb;
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit done = 0, ram_checked = 0, inited = 0;

    mem_port_arbiter #(.FAIR(FAIR)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int k);
        return 32'h9E37_79B9 * k + 32'h0000_1234;
    endfunction

    // Physical RAM: 16 words, one-cycle registered read.
    logic [31:0] ram [16];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0)
            for (int k = 0; k < 16; k++) ram[k] <= init_word(k);
        else if (mem_we)
            ram[mem_addr[5:2]] <= mem_din;
        mem_dout <= ram[mem_addr[5:2]];
    end

    typedef struct {
        bit is_d;
        bit is_load;
        logic [31:0] data;
        int cyc;
    } exp_t;
    exp_t sb[$];

    // Reference model: serialized accesses, arbitration by the last-winner rule.
    logic [31:0] ref_mem [16];
    int busy = 0;
    bit m_last_d = 0;
    logic [3:0] p_w;
    logic [31:0] p_data, p_mask;
    always @(negedge clk) begin
        logic [1:0] eg;
        logic ew;
        logic [3:0] w;
        if (!inited) begin
            for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
            inited = 1;
        end
        eg = 2'b00;
        ew = 1'b0;
        if (rst) begin
            busy = 0;
            m_last_d = 0;
            sb.delete();
        end else if (busy == 0) begin
            if (d_req && (!i_req || !FAIR || !m_last_d)) begin
                eg = 2'b01;
                m_last_d = 1;
                w = d_addr[5:2];
                if (!d_we) begin
                    sb.push_back(exp_t'{1'b1, 1'b1, ref_mem[w], cyc + 1});
                    busy = 1;
                end else if (d_wstrb == 4'hf || d_wstrb == 4'h0) begin
                    if (d_wstrb == 4'hf) begin
                        ref_mem[w] = d_wdata;
                        ew = 1'b1;
                    end
                    sb.push_back(exp_t'{1'b1, 1'b0, 32'h0, cyc + 1});
                    busy = 1;
                end else begin
                    p_w = w;
                    p_data = d_wdata;
                    p_mask = 32'h0;
                    for (int k = 0; k < 4; k++) if (d_wstrb[k]) p_mask = p_mask | (32'hFF << (8 * k));
                    sb.push_back(exp_t'{1'b1, 1'b0, 32'h0, cyc + 2});
                    busy = 2;
                end
            end else if (i_req) begin
                eg = 2'b10;
                m_last_d = 0;
                sb.push_back(exp_t'{1'b0, 1'b1, ref_mem[i_addr[5:2]], cyc + 1});
                busy = 1;
            end
        end else begin
            if (busy == 2) begin
                ew = 1'b1;
                ref_mem[p_w] = (ref_mem[p_w] & ~p_mask) | (p_data & p_mask);
            end
            busy--;
        end
        n_chk++;
        if ({i_gnt, d_gnt} !== eg) begin
            n_fail++;
            $display("FAIL grant cyc=%0d: got i/d=%b, expected %b", cyc, {i_gnt, d_gnt}, eg);
        end
        n_chk++;
        if (mem_we !== ew) begin
            n_fail++;
            $display("FAIL mem_we cyc=%0d: got %b, expected %b", cyc, mem_we, ew);
        end
        if (rst) begin
            n_chk++;
            if (mem_addr !== 32'h0 || mem_din !== 32'h0 || i_ack || d_ack) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d: addr=%h din=%h ack=%b%b, expected zeros",
                         cyc, mem_addr, mem_din, i_ack, d_ack);
            end
        end
    end

    // Monitor: pops one expectation per ack and checks owner, timing and data.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_ack: %s ack due at cyc %0d, no ack by cyc %0d",
                     e.is_d ? "d" : "i", e.cyc, cyc);
        end
        if (i_ack || d_ack) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_ack cyc=%0d: got i/d ack=%b%b, expected none", cyc, i_ack, d_ack);
            end else begin
                e = sb.pop_front();
                if ((i_ack && d_ack) || e.is_d != d_ack || e.cyc != cyc ||
                    (e.is_load && (d_ack ? d_rdata : i_rdata) !== e.data)) begin
                    n_fail++;
                    $display("FAIL ack cyc=%0d: got i/d=%b%b rdata=%h, expected %s at cyc %0d data=%h",
                             cyc, i_ack, d_ack, d_ack ? d_rdata : i_rdata,
                             e.is_d ? "d" : "i", e.cyc, e.data);
                end
            end
        end
        if (done && !ram_checked) begin
            ram_checked = 1;
            for (int k = 0; k < 16; k++) begin
                n_chk++;
                if (ram[k] !== ref_mem[k]) begin
                    n_fail++;
                    $display("FAIL ram_word[%0d]: got %h, expected %h", k, ram[k], ref_mem[k]);
                end
            end
        end
    end

    initial begin
        logic [3:0] strb_tbl [3];
        strb_tbl[0] = 4'hf;
        strb_tbl[1] = 4'h0;
        strb_tbl[2] = 4'h5;
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        // Both requesters held high from reset: D must win the first tie, then alternate.
        i_req = 1; d_req = 1; d_we = 0;
        i_addr = 32'h40; d_addr = 32'h8;
        repeat (12) @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            i_req = $urandom_range(0, 2) != 0;
            d_req = $urandom_range(0, 2) != 0;
            d_we = $urandom_range(0, 1) == 1;
            i_addr = $urandom;
            d_addr = $urandom;
            d_wdata = $urandom;
            d_wstrb = $urandom_range(0, 3) == 3 ? strb_tbl[$urandom_range(0, 2)] : 4'($urandom);
            rst = $urandom_range(0, 59) == 0;
            @(posedge clk);
            #1;
        end
        // Partial store followed by reset in its merge cycle: the word must stay untouched.
        rst = 0; i_req = 0;
        d_req = 1; d_we = 1; d_addr = 32'h4; d_wstrb = 4'b0100; d_wdata = 32'h00AB_0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_gnt) break;
        end
        @(posedge clk);
        #1 d_req = 0; d_addr = 32'h3C; d_wdata = 32'hFFFF_FFFF; rst = 1;
        @(posedge clk);
        #1 rst = 0;
        // Partial store whose inputs change right after the grant.
        d_req = 1; d_we = 1; d_addr = 32'h8; d_wstrb = 4'b0010; d_wdata = 32'h0000_5A00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_gnt) break;
        end
        @(posedge clk);
        #1 d_req = 0; d_addr = 32'h0; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hf;
        repeat (6) @(posedge clk);
        done = 1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
